// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for a uart_rx instance. It gates the receiver enable, handles BREAK,
// and tracks the idle gap between bytes. Received bytes go into a FWFT FIFO with a valid/ready port.
module uart_rx_ctrl #(
    parameter int PAYLOAD_BITS  = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int IDLE_CYCLES   = 52080,
    parameter int BREAK_RELEASE = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ctrl_enable,
    input  logic                            fifo_flush,
    input  logic                            overrun_clr,
    input  logic                            uart_rxd,
    output logic                            uart_rx_en,
    input  logic                            rx_valid,
    input  logic                            rx_break,
    input  logic [PAYLOAD_BITS-1:0]         rx_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [PAYLOAD_BITS-1:0]         m_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overrun,
    output logic                            break_det,
    output logic                            idle_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int RW = $clog2(BREAK_RELEASE + 1);

    typedef enum logic [1:0] {ST_OFF, ST_ACTIVE, ST_BREAK_WAIT} state_t;

    state_t                  state, state_nxt;
    logic [RW-1:0]           rel_cnt;
    logic                    rel_done;
    logic                    in_active, push, brk, pop, full, wr_en, drop;
    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [IW-1:0]           idle_cnt;
    logic                    idle_armed;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_OFF;
        else       state <= state_nxt;
    end

    assign rel_done = uart_rxd && (rel_cnt == RW'(BREAK_RELEASE - 1));

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (!ctrl_enable) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:        state_nxt = ST_ACTIVE;
                ST_ACTIVE:     if (rx_valid && rx_break) state_nxt = ST_BREAK_WAIT;
                ST_BREAK_WAIT: if (rel_done) state_nxt = ST_ACTIVE;
                default:       state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        uart_rx_en = (state != ST_OFF);
    end

    // Run of consecutive high line samples, only meaningful while waiting out a BREAK
    always_ff @(posedge clk) begin
        if (reset || state != ST_BREAK_WAIT) rel_cnt <= '0;
        else if (uart_rxd)                   rel_cnt <= rel_cnt + RW'(1);
        else                                 rel_cnt <= '0;
    end

    assign in_active = (state == ST_ACTIVE);
    assign push      = rx_valid && !rx_break && in_active;
    assign brk       = rx_valid && rx_break && in_active;
    assign m_valid   = (fifo_level != '0);
    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    assign pop       = m_valid && m_ready;
    assign wr_en     = push && (!full || pop) && !fifo_flush;
    assign drop      = push && full && !pop && !fifo_flush;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;

    // NOTE: the storage array has no reset; m_data is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset || fifo_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            break_det <= brk;
            if (drop)             overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    // Idle gap timer: restarted by every received byte, armed only by bytes that were pushed
    always_ff @(posedge clk) begin
        if (reset || !in_active) begin
            idle_cnt     <= '0;
            idle_armed   <= 1'b0;
            idle_timeout <= 1'b0;
        end else begin
            idle_timeout <= 1'b0;
            if (rx_valid) begin
                idle_cnt   <= '0;
                idle_armed <= push;
            end else if (idle_armed) begin
                if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
                    idle_cnt     <= '0;
                    idle_armed   <= 1'b0;
                    idle_timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios with literal expectations, then random traffic.
// Every cycle the DUT outputs are compared against a queue-based behavioural model.
module tb_uart_rx_ctrl;

    localparam int PB    = 8;
    localparam int DEPTH = 8;
    localparam int IDLE  = 40;
    localparam int REL   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ctrl_enable = 1'b0;
    logic          fifo_flush = 1'b0;
    logic          overrun_clr = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          rx_valid = 1'b0;
    logic          rx_break = 1'b0;
    logic [PB-1:0] rx_data = '0;
    logic          m_ready = 1'b0;
    logic          uart_rx_en, m_valid, overrun, break_det, idle_timeout;
    logic [PB-1:0] m_data;
    logic [3:0]    fifo_level;

    uart_rx_ctrl #(
        .PAYLOAD_BITS(PB), .FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .BREAK_RELEASE(REL)
    ) dut (
        .clk(clk), .reset(reset), .ctrl_enable(ctrl_enable), .fifo_flush(fifo_flush),
        .overrun_clr(overrun_clr), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
        .rx_valid(rx_valid), .rx_break(rx_break), .rx_data(rx_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .fifo_level(fifo_level),
        .overrun(overrun), .break_det(break_det), .idle_timeout(idle_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte queue, mode, BREAK release streak, idle deadline
    typedef enum int {M_OFF, M_ACTIVE, M_BW} mode_t;
    mode_t         mode = M_OFF;
    logic [PB-1:0] q[$];
    bit            m_ovr = 0, m_brk = 0, m_idle = 0, armed = 0;
    bit            act, mpush, mpop, mfull, set_ovr;
    int            streak = 0, cyc = 0, deadline = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mode = M_OFF; q.delete(); m_ovr = 0; m_brk = 0; m_idle = 0; armed = 0; streak = 0;
        end else begin
            act   = (mode == M_ACTIVE);
            mpush = rx_valid && !rx_break && act;
            mpop  = (q.size() != 0) && m_ready;
            mfull = (q.size() == DEPTH);
            m_brk = rx_valid && rx_break && act;
            m_idle = 0;
            if (!act) armed = 0;
            else if (rx_valid) begin armed = mpush; deadline = cyc + IDLE; end
            else if (armed && cyc == deadline) begin m_idle = 1; armed = 0; end
            set_ovr = 0;
            if (fifo_flush) q.delete();
            else begin
                if (mpop) void'(q.pop_front());
                if (mpush) begin
                    if (mfull && !mpop) set_ovr = 1;
                    else q.push_back(rx_data);
                end
            end
            if (set_ovr) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            if (!ctrl_enable) begin mode = M_OFF; streak = 0; end
            else if (mode == M_OFF) mode = M_ACTIVE;
            else if (mode == M_ACTIVE) begin
                if (rx_valid && rx_break) begin mode = M_BW; streak = 0; end
            end else begin
                streak = uart_rxd ? streak + 1 : 0;
                if (streak == REL) begin mode = M_ACTIVE; streak = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("uart_rx_en", uart_rx_en, (mode != M_OFF));
            check("m_valid", m_valid, (q.size() != 0));
            check("m_data", m_data, (q.size() != 0) ? q[0] : 8'h00);
            check("fifo_level", fifo_level, q.size());
            check("overrun", overrun, m_ovr);
            check("break_det", break_det, m_brk);
            check("idle_timeout", idle_timeout, m_idle);
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [PB-1:0] d);
        rx_valid = 1'b1; rx_data = d;
        go();
        rx_valid = 1'b0;
    endtask

    int k, pulses;
    bit found;
    logic [PB-1:0] last;

    initial begin
        // 1: reset state, enable, two bytes through
        go();
        chk_on = 1'b1;
        reset = 1'b0;
        check("rst_en", uart_rx_en, 0);
        check("rst_level", fifo_level, 0);
        check("rst_mdata", m_data, 0);
        ctrl_enable = 1'b1;
        go();
        check("en_after_1", uart_rx_en, 1);
        push_byte(8'h55);
        check("lvl1", fifo_level, 1);
        push_byte(8'hA3);
        check("lvl2", fifo_level, 2);
        check("head55", m_data, 8'h55);
        m_ready = 1'b1;
        go();
        check("headA3", m_data, 8'hA3);
        go();
        check("drained", m_valid, 0);
        m_ready = 1'b0;

        // 2: overrun on a full FIFO
        for (int i = 1; i <= 9; i++) push_byte(PB'(i));
        check("full_lvl", fifo_level, 8);
        check("ovr_set", overrun, 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("pop_order", m_data, i);
            go();
        end
        m_ready = 1'b0;
        check("pop_empty", fifo_level, 0);
        overrun_clr = 1'b1;
        go();
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // 3: full + push + pop
        for (int i = 0; i < 8; i++) push_byte(PB'(8'h10 + i));
        m_ready = 1'b1;
        push_byte(8'h77);
        m_ready = 1'b0;
        check("fpp_lvl", fifo_level, 8);
        check("fpp_ovr", overrun, 0);
        check("fpp_head", m_data, 8'h11);
        m_ready = 1'b1;
        last = 8'h00;
        for (int i = 0; i < 8; i++) begin last = m_data; go(); end
        m_ready = 1'b0;
        check("fpp_last", last, 8'h77);

        // 4: BREAK handling
        rx_break = 1'b1;
        push_byte(8'h00);
        rx_break = 1'b0;
        uart_rxd = 1'b0;
        check("brk_pulse", break_det, 1);
        check("brk_lvl", fifo_level, 0);
        go();
        check("brk_once", break_det, 0);
        check("bw_en", uart_rx_en, 1);
        push_byte(8'h11);
        check("bw_ignored", fifo_level, 0);
        uart_rxd = 1'b1;
        repeat (15) go();
        uart_rxd = 1'b0;
        go();
        uart_rxd = 1'b1;
        repeat (15) go();
        push_byte(8'h33);
        check("bw_last_cycle", fifo_level, 0);
        push_byte(8'h22);
        check("post_bw_lvl", fifo_level, 1);
        check("post_bw_data", m_data, 8'h22);
        m_ready = 1'b1;
        go();
        m_ready = 1'b0;

        // 5: idle timeout
        push_byte(8'h42);
        k = 0; found = 0;
        while (k < 200 && !found) begin go(); k++; if (idle_timeout) found = 1; end
        check("idle_delay", k, IDLE);
        pulses = 0;
        repeat (60) begin go(); if (idle_timeout) pulses++; end
        check("idle_once", pulses, 0);
        push_byte(8'h43);
        repeat (IDLE - 2) go();
        push_byte(8'h44);
        go();
        check("idle_cancel", idle_timeout, 0);
        k = 1; found = 0;
        while (k < 200 && !found) begin go(); k++; if (idle_timeout) found = 1; end
        check("idle_rearm", k, IDLE);
        check("lvl3", fifo_level, 3);

        // 6: flush with push, then reset mid-stream
        fifo_flush = 1'b1;
        push_byte(8'h99);
        fifo_flush = 1'b0;
        check("flush_lvl", fifo_level, 0);
        check("flush_ovr", overrun, 0);
        push_byte(8'h5A);
        push_byte(8'h5B);
        reset = 1'b1;
        push_byte(8'h5C);
        reset = 1'b0;
        ctrl_enable = 1'b0;
        check("r_en", uart_rx_en, 0);
        check("r_valid", m_valid, 0);
        check("r_data", m_data, 0);
        check("r_lvl", fifo_level, 0);
        check("r_ovr", overrun, 0);
        check("r_brk", break_det, 0);
        check("r_idle", idle_timeout, 0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(999) < 2);
            ctrl_enable = ($urandom_range(99) < 93);
            rx_valid    = ($urandom_range(99) < 30);
            rx_break    = ($urandom_range(99) < 6);
            rx_data     = PB'($urandom);
            m_ready     = ($urandom_range(99) < 45);
            fifo_flush  = ($urandom_range(99) < 2);
            overrun_clr = ($urandom_range(99) < 3);
            uart_rxd    = ($urandom_range(99) < 88);
            go();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
